// File: rtl/cnn_pkg.sv
// Shared data type and element-wise helpers for the CNN streaming stages.
package cnn_pkg;
  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] data_t;

  function automatic data_t smax(input data_t a, input data_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic data_t relu(input data_t v);
    return v[DATA_W-1] ? '0 : v;
  endfunction
endpackage

// File: rtl/relu_maxpool_ctrl.sv
// Element/window position tracking for the max-pool stage; advances once per accepted sample.
module relu_maxpool_ctrl #(
  parameter int L = 29,
  parameter int K = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  output logic win_first,
  output logic win_done,
  output logic tail
);
  localparam int POOL_FULL = (L / K) * K;
  // One extra bit of headroom so POOL_FULL still fits when L is a power of two
  localparam int PW = $clog2(L + 1);
  localparam int WW = $clog2(K);

  logic [PW-1:0] pos_reg;
  logic [WW-1:0] win_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_reg <= '0;
      win_reg <= '0;
    end else if (advance) begin
      if (pos_reg == PW'(L - 1)) begin
        pos_reg <= '0;
        win_reg <= '0;
      end else begin
        pos_reg <= pos_reg + 1'b1;
        win_reg <= (win_reg == WW'(K - 1)) ? '0 : win_reg + 1'b1;
      end
    end
  end

  assign win_first = (win_reg == '0);
  assign win_done  = (win_reg == WW'(K - 1));
  assign tail      = (pos_reg >= PW'(POOL_FULL));
endmodule

// File: rtl/relu_maxpool_29_2_16.sv
// Streaming ReLU + non-overlapping 1-D max-pool with valid/ready on both sides.
module relu_maxpool_29_2_16
  import cnn_pkg::*;
#(
  parameter int L    = 29,
  parameter int K    = 2,
  parameter int T    = 16,
  parameter int RELU = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] s_data_in_x,
  input  logic         s_valid_x,
  output logic         s_ready_x,
  output logic [T-1:0] m_data_out_y,
  output logic         m_valid_y,
  input  logic         m_ready_y
);
  logic  in_xfer;
  logic  win_first;
  logic  win_done;
  logic  tail;
  data_t x_in;
  data_t acc_reg;
  data_t win_max;
  data_t pooled;
  data_t out_reg;
  logic  m_valid_reg;

  relu_maxpool_ctrl #(
    .L(L),
    .K(K)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .advance  (in_xfer),
    .win_first(win_first),
    .win_done (win_done),
    .tail     (tail)
  );

  // Ready depends only on the output register state and downstream ready
  assign s_ready_x = !m_valid_reg || m_ready_y;
  assign in_xfer   = s_valid_x && s_ready_x;

  assign x_in    = s_data_in_x;
  assign win_max = win_first ? x_in : smax(acc_reg, x_in);
  assign pooled  = (RELU != 0) ? relu(win_max) : win_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg     <= '0;
      out_reg     <= '0;
      m_valid_reg <= 1'b0;
    end else begin
      if (in_xfer) begin
        acc_reg <= win_max;
      end
      // A completing window wins over draining so a simultaneous handoff keeps valid high
      if (in_xfer && win_done && !tail) begin
        out_reg     <= pooled;
        m_valid_reg <= 1'b1;
      end else if (m_ready_y) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  assign m_data_out_y = out_reg;
  assign m_valid_y    = m_valid_reg;
endmodule
